// File: rtl/serial_run_detect.sv
// serial_run_detect: run-length detector on a single-bit serial stream.
// Asserts ostream while the current run of matching samples is at least
// RUN_LEN long. Match modes: 00 = runs of 1s, 01 = runs of 0s,
// 10 = runs of either value, 11 = same as 00.
// Optional build macro SERIAL_RUN_STATS_EN adds end_pulse/last_run_len,
// which report the length of each detected run when it terminates.
module serial_run_detect #(
   parameter int RUN_LEN = 4,
   parameter int CNT_W   = 3,
   parameter int TOT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             istream,
   input  logic             ivalid,
   input  logic [1:0]       mode,
   output logic             ostream,
   output logic             det_pulse,
   output logic [CNT_W-1:0] run_len,
   output logic             run_bit,
   output logic [TOT_W-1:0] run_total
`ifdef SERIAL_RUN_STATS_EN
   ,
   output logic             end_pulse,
   output logic [CNT_W-1:0] last_run_len
`endif
);

   typedef enum logic [1:0] {
      MODE_ONES   = 2'b00,
      MODE_ZEROS  = 2'b01,
      MODE_EITHER = 2'b10
   } mode_e;

   localparam logic [CNT_W-1:0] LEN_MAX = '1;
   localparam logic [TOT_W-1:0] TOT_MAX = '1;
   localparam logic [CNT_W-1:0] RUN_THR = CNT_W'(RUN_LEN);

   // A RUN_LEN outside 1..2^CNT_W-1 could never be reached (or is always met).
   generate
      if (RUN_LEN < 1 || RUN_LEN > (2 ** CNT_W) - 1) begin : g_bad_run_len
         initial $error("serial_run_detect: RUN_LEN=%0d outside 1..%0d",
                        RUN_LEN, (2 ** CNT_W) - 1);
      end
   endgenerate

   mode_e            mode_n;
   mode_e            mode_q;
   logic             match;
   logic [CNT_W-1:0] len_inc;
   logic [CNT_W-1:0] len_n;
   logic             bit_n;
   logic             os_n;
   logic             det_n;
   logic [TOT_W-1:0] total_n;
`ifdef SERIAL_RUN_STATS_EN
   logic             end_n;
`endif

   // Fold the reserved encoding onto "runs of 1s" so 00 <-> 11 is not a mode change.
   always_comb begin
      unique case (mode)
         2'b01:   mode_n = MODE_ZEROS;
         2'b10:   mode_n = MODE_EITHER;
         default: mode_n = MODE_ONES;
      endcase
   end

   // Next-state for the run tracker: mode change clears, valid sample advances, else hold.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      len_inc = (run_len == LEN_MAX) ? run_len : run_len + CNT_W'(1);
      match   = 1'b0;
      len_n   = run_len;
      bit_n   = run_bit;
      os_n    = ostream;
      total_n = run_total;
      if (mode_n != mode_q) begin
         // The sample arriving with a mode change is discarded.
         len_n = '0;
         os_n  = 1'b0;
      end else if (ivalid) begin
         if (mode_q == MODE_EITHER) begin
            // An empty run adopts the incoming bit; a different bit starts a fresh run of 1.
            match = (run_len == '0) || (istream == run_bit);
            bit_n = istream;
            len_n = match ? len_inc : CNT_W'(1);
            os_n  = match && (len_inc >= RUN_THR);
         end else begin
            match = (istream == (mode_q == MODE_ONES));
            len_n = match ? len_inc : '0;
            os_n  = match && (len_inc >= RUN_THR);
         end
      end
      // Rising edge of ostream is a detection; it can only happen on a valid sample.
      det_n = os_n & ~ostream;
      if (det_n && run_total != TOT_MAX) begin
         total_n = run_total + TOT_W'(1);
      end
`ifdef SERIAL_RUN_STATS_EN
      end_n = ostream & ~os_n;
`endif
   end

   // State and output registers; synchronous reset has priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q       <= MODE_ONES;
         ostream      <= 1'b0;
         det_pulse    <= 1'b0;
         run_len      <= '0;
         run_bit      <= 1'b0;
         run_total    <= '0;
`ifdef SERIAL_RUN_STATS_EN
         end_pulse    <= 1'b0;
         last_run_len <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         mode_q       <= mode_n;
         ostream      <= os_n;
         det_pulse    <= det_n;
         run_len      <= len_n;
         run_bit      <= bit_n;
         run_total    <= total_n;
`ifdef SERIAL_RUN_STATS_EN
         end_pulse    <= end_n;
         if (end_n) begin
            last_run_len <= run_len;
         end
`endif
      end
   end

endmodule

// File: tb/tb_serial_run_detect.sv
// Testbench for serial_run_detect: table-driven vectors with a scoreboard queue,
// plus hand-written sequences for mid-run events and run_total saturation.
// The end_pulse/last_run_len checks apply when SERIAL_RUN_STATS_EN is defined.
module tb_serial_run_detect;

   logic       clk = 1'b0;
   logic       rst;
   logic       istream;
   logic       ivalid;
   logic [1:0] mode;

   logic       ostream, det_pulse, run_bit;
   logic [2:0] run_len;
   logic [7:0] run_total;
   logic       ostream2, det_pulse2, run_bit2;
   logic [2:0] run_len2;
   logic [1:0] run_total2;
`ifdef SERIAL_RUN_STATS_EN
   logic       end_pulse, end_pulse2;
   logic [2:0] last_run_len, last_run_len2;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_run_detect dut (
      .clk(clk), .rst(rst), .istream(istream), .ivalid(ivalid), .mode(mode),
      .ostream(ostream), .det_pulse(det_pulse), .run_len(run_len),
      .run_bit(run_bit), .run_total(run_total)
`ifdef SERIAL_RUN_STATS_EN
      , .end_pulse(end_pulse), .last_run_len(last_run_len)
`endif
   );

   serial_run_detect #(.TOT_W(2)) dut_tot2 (
      .clk(clk), .rst(rst), .istream(istream), .ivalid(ivalid), .mode(mode),
      .ostream(ostream2), .det_pulse(det_pulse2), .run_len(run_len2),
      .run_bit(run_bit2), .run_total(run_total2)
`ifdef SERIAL_RUN_STATS_EN
      , .end_pulse(end_pulse2), .last_run_len(last_run_len2)
`endif
   );

   typedef struct packed {
      logic       s;
      logic       v;
      logic [1:0] m;
      logic [2:0] e_len;
      logic       e_os;
      logic       e_det;
      logic [7:0] e_tot;
      logic       e_bit;   // x = not checked
      logic       e_end;   // x = not checked
      logic [2:0] e_last;  // x = not checked
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[$];

   function automatic vec_t mk(logic s, logic v, logic [1:0] m, logic [2:0] len,
                               logic os, logic det, logic [7:0] tot,
                               logic b = 1'bx, logic en = 1'bx, logic [2:0] last = 3'bxxx);
      vec_t r;
      r.s = s; r.v = v; r.m = m; r.e_len = len; r.e_os = os; r.e_det = det;
      r.e_tot = tot; r.e_bit = b; r.e_end = en; r.e_last = last;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one vector, queue its expectation, compare after the edge.
   task automatic apply(input string tag, input vec_t v);
      vec_t e;
      istream = v.s; ivalid = v.v; mode = v.m;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, " queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, " run_len"},   32'(run_len),   32'(e.e_len));
         check({tag, " ostream"},   32'(ostream),   32'(e.e_os));
         check({tag, " det_pulse"}, 32'(det_pulse), 32'(e.e_det));
         check({tag, " run_total"}, 32'(run_total), 32'(e.e_tot));
         if (!$isunknown(e.e_bit)) check({tag, " run_bit"}, 32'(run_bit), 32'(e.e_bit));
`ifdef SERIAL_RUN_STATS_EN
         if (!$isunknown(e.e_end))  check({tag, " end_pulse"}, 32'(end_pulse), 32'(e.e_end));
         if (!$isunknown(e.e_last)) check({tag, " last_run_len"}, 32'(last_run_len), 32'(e.e_last));
`endif
      end
   endtask

   task automatic run_table(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         apply($sformatf("%s[%0d]", name, i), tbl[i]);
      end
      tbl.delete();
   endtask

   // One reset edge with the given sample inputs; every output must read 0 after it.
   task automatic do_reset(input logic s, input logic v, input logic [1:0] m);
      rst = 1'b1; istream = s; ivalid = v; mode = m;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset ostream",   32'(ostream),   32'd0);
      check("reset det_pulse", 32'(det_pulse), 32'd0);
      check("reset run_len",   32'(run_len),   32'd0);
      check("reset run_bit",   32'(run_bit),   32'd0);
      check("reset run_total", 32'(run_total), 32'd0);
      check("reset run_total2", 32'(run_total2), 32'd0);
`ifdef SERIAL_RUN_STATS_EN
      check("reset end_pulse",    32'(end_pulse),    32'd0);
      check("reset last_run_len", 32'(last_run_len), 32'd0);
`endif
   endtask

   initial begin
      int dets;
      rst = 1'b0; istream = 1'b0; ivalid = 1'b0; mode = 2'b00;
      @(posedge clk);
      #1;

      // Mode 00, stream 11011111101011110 (first bit sent first).
      do_reset(1'b0, 1'b0, 2'b00);
      tbl.push_back(mk(1, 1, 2'b00, 1, 0, 0, 0, 1'bx, 0, 0));
      tbl.push_back(mk(1, 1, 2'b00, 2, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b00, 0, 0, 0, 0, 1'bx, 0, 0));
      tbl.push_back(mk(1, 1, 2'b00, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'b00, 2, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'b00, 3, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'b00, 4, 1, 1, 1));
      tbl.push_back(mk(1, 1, 2'b00, 5, 1, 0, 1));
      tbl.push_back(mk(1, 1, 2'b00, 6, 1, 0, 1));
      tbl.push_back(mk(0, 1, 2'b00, 0, 0, 0, 1, 1'bx, 1, 6));
      tbl.push_back(mk(1, 1, 2'b00, 1, 0, 0, 1, 1'bx, 0, 6));
      tbl.push_back(mk(0, 1, 2'b00, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2'b00, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2'b00, 2, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2'b00, 3, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2'b00, 4, 1, 1, 2));
      tbl.push_back(mk(0, 1, 2'b00, 0, 0, 0, 2, 1'bx, 1, 4));
      run_table("m00");

      // Mode 01, ten zeros: saturate at 7, single detection.
      do_reset(1'b0, 1'b0, 2'b00);
      tbl.push_back(mk(0, 0, 2'b01, 0, 0, 0, 0));  // settles the registered mode
      for (int i = 1; i <= 10; i++) begin
         tbl.push_back(mk(0, 1, 2'b01, (i > 7) ? 3'd7 : 3'(i), (i >= 4), (i == 4),
                          (i >= 4) ? 8'd1 : 8'd0));
      end
      run_table("m01");

      // Mode 10, stream 1110000111: bit change at RUN_LEN-1, then a 0-run of 4.
      do_reset(1'b0, 1'b0, 2'b00);
      tbl.push_back(mk(0, 0, 2'b10, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 2'b10, 1, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2'b10, 2, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 2'b10, 3, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 2'b10, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b10, 2, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b10, 3, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b10, 4, 1, 1, 1, 0));
      tbl.push_back(mk(1, 1, 2'b10, 1, 0, 0, 1, 1, 1, 4));
      tbl.push_back(mk(1, 1, 2'b10, 2, 0, 0, 1, 1));
      tbl.push_back(mk(1, 1, 2'b10, 3, 0, 0, 1, 1));
      run_table("m10");

      // Mode 00 with ivalid toggling: gaps hold the run.
      do_reset(1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 8; i++) begin
         tbl.push_back(mk(1, (i % 2 == 0), 2'b00, 3'(i / 2 + 1), (i >= 6), (i == 6),
                          (i >= 6) ? 8'd1 : 8'd0));
      end
      run_table("gap");

      // Mode change 00 -> 01 at run_len=5, then reset in the middle of a detected run.
      do_reset(1'b0, 1'b0, 2'b00);
      for (int i = 1; i <= 5; i++) begin
         apply($sformatf("pre_chg[%0d]", i),
               mk(1, 1, 2'b00, 3'(i), (i >= 4), (i == 4), (i >= 4) ? 8'd1 : 8'd0));
      end
      apply("mode_chg",      mk(0, 1, 2'b01, 0, 0, 0, 1, 1'bx, 1, 5));
      apply("mode_chg_hold", mk(0, 0, 2'b01, 0, 0, 0, 1, 1'bx, 0, 5));
      for (int i = 1; i <= 4; i++) begin
         apply($sformatf("post_chg[%0d]", i),
               mk(0, 1, 2'b01, 3'(i), (i == 4), (i == 4), (i == 4) ? 8'd2 : 8'd1, 1'bx, 0, 5));
      end
      do_reset(1'b0, 1'b1, 2'b01);

      // run_total saturation on the TOT_W=2 instance: five separated runs.
      do_reset(1'b0, 1'b0, 2'b00);
      dets = 0;
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 5; k++) begin
            istream = (k < 4); ivalid = 1'b1; mode = 2'b00;
            @(posedge clk);
            #1;
            if (det_pulse2) dets++;
            if (k == 3) begin
               check($sformatf("sat det_pulse2[%0d]", r), 32'(det_pulse2), 32'd1);
               check($sformatf("sat run_total2[%0d]", r), 32'(run_total2),
                     (r + 1 > 3) ? 32'd3 : 32'(r + 1));
               check($sformatf("sat run_total[%0d]", r), 32'(run_total), 32'(r + 1));
            end
         end
      end
      check("sat det_pulse2 count", 32'(dets), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
